cell_frame_writer: RTL and testbench
====================================

# cell_frame_writer

Downstream consumer of the cell processor core. Takes the stream of processed cells, buffers them in a small FIFO, and writes them into a frame buffer through a simple valid/ready memory write port. Addresses are generated in raster order from a per-frame base address. Completion of one full frame of IMG_W × IMG_H cells is signalled, and any cell arriving while the buffer is full is flagged.

## Interface
Parameters:
- CELL_W, default CellProcessingPkg::cellDepth: width of one processed cell.
- IMG_W, default 640: cells per line.
- IMG_H, default 480: lines per frame.
- ADDR_W, default 20: memory address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- FIFO_DEPTH, default 4: input buffer entries; power of two, ≥ 2.

Ports:
- clk, input, 1: the single clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that arms a frame; honoured only in IDLE.
- base_addr, input, ADDR_W: frame base address; sampled on the cycle start is accepted.
- in_valid, input, 1: processedCell is valid this cycle.
- in_data, input, CELL_W: processed cell.
- in_ready, output, 1: writer will accept a cell this cycle.
- mem_wr_en, output, 1: write request valid.
- mem_wr_addr, output, ADDR_W: write address.
- mem_wr_data, output, CELL_W: write data.
- mem_ready, input, 1: memory accepts the request this cycle.
- busy, output, 1: state is not IDLE.
- frame_done, output, 1: one-cycle pulse at frame completion.
- overflow, output, 1: sticky; a cell was dropped.

## Operation
- States: IDLE, ACTIVE, DRAIN.
  - IDLE → ACTIVE on start. This clears in_cnt, out_cnt and overflow, and loads addr ← base_addr.
  - ACTIVE → DRAIN on the cycle in_cnt reaches IMG_W·IMG_H.
  - DRAIN → IDLE on the cycle the last write completes (out_cnt reaches IMG_W·IMG_H). frame_done pulses on that cycle.
- Input acceptance:
  - in_ready = (state == ACTIVE) && !fifo_full.
  - A cell is accepted when in_valid && in_ready; in_cnt increments on each accept.
  - in_valid && !in_ready in ACTIVE: the cell is dropped and overflow is set. It stays set until the next start or rst.
  - in_valid in IDLE or DRAIN: ignored, and does not set overflow.
- Output stage:
  - One output register holds {mem_wr_en, mem_wr_addr, mem_wr_data}.
  - When the register is empty, or accepted this cycle (mem_wr_en && mem_ready), it loads the FIFO head if the FIFO is non-empty; otherwise mem_wr_en drops to 0.
  - While mem_wr_en && !mem_ready, addr and data hold stable.
- Addressing:
  - mem_wr_addr = base_addr + out_cnt, where out_cnt is the count of cells handed to the output register this frame.
  - addr increments by 1 per output-register load, with no wrap inside a frame. It wraps modulo 2^ADDR_W (unsigned).
  - Internal col/row counters drive completion: col wraps IMG_W-1 → 0 and then increments row; the final cell is row IMG_H-1, col IMG_W-1.
- FIFO:
  - Simultaneous push and pop allowed at any non-full, non-empty level.
  - A push into an empty FIFO is not bypassed to the output stage.
- start while busy: ignored, with no effect on base_addr or counters.

## Timing
- Reset values:
  - in_ready = 0, mem_wr_en = 0, mem_wr_addr = 0, mem_wr_data = 0.
  - busy = 0, frame_done = 0, overflow = 0.
  - FIFO empty, state IDLE, all counters 0.
- start accepted in cycle T: busy = 1 and in_ready = 1 from cycle T+1.
- Cell accepted in cycle N with the FIFO empty and the output register idle: mem_wr_en = 1 in cycle N+2 (latency 2).
- Sustained throughput with mem_ready held high: one cell per cycle.
- frame_done is a one-cycle pulse in the cycle after the final mem_wr_en && mem_ready. busy = 0 in that same cycle.
- rst mid-frame: all state is discarded on the next edge, FIFO contents are lost, and no further writes are issued.

## Test plan
Benches use IMG_W = 4, IMG_H = 2, FIFO_DEPTH = 4, ADDR_W = 8.
- Basic frame: base_addr = 0x10, start, 8 back-to-back cells 1..8, mem_ready = 1.
  - Writes go to 0x10..0x17 with data 1..8.
  - First mem_wr_en is 2 cycles after the first accept.
  - frame_done pulses once; overflow = 0.
- Backpressure: mem_ready = 0 for 6 cycles mid-frame.
  - in_ready drops once 4 cells are buffered plus 1 in the output register.
  - Address and data stay stable while stalled; no data loss, order preserved.
- Overflow: the same stall with in_valid held high.
  - overflow is set; the dropped cells are absent from memory.
  - Overflow is cleared by the next start.
- Ignore cases:
  - in_valid in IDLE produces no writes.
  - start pulsed mid-frame does not change base_addr.
  - Cells 9+ offered in DRAIN are ignored and in_ready = 0.
- Address wrap: base_addr = 0xFC, 8 cells.
  - Addresses 0xFC..0xFF, then 0x00..0x03.
- Reset mid-frame: rst after 3 writes.
  - All outputs return to reset values on the next cycle.
  - A new start with base_addr = 0x40 writes 0x40..0x47 cleanly.

Source files
------------

// File: rtl/cell_frame_writer.sv
// cell_frame_writer: buffers processed cells in a small FIFO and writes one frame in raster order to memory.
package CellProcessingPkg;
  localparam int cellDepth = 8;
endpackage

module cell_frame_writer #(
  parameter int CELL_W = CellProcessingPkg::cellDepth,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int ADDR_W = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [CELL_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [CELL_W-1:0] mem_wr_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW = $clog2(TOTAL + 1);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t            state_q;
  logic [CELL_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q;
  logic [CW-1:0]     in_cnt_q;
  logic [XW-1:0]     col_q;
  logic [YW-1:0]     row_q;
  logic [ADDR_W-1:0] addr_q, wr_addr_q;
  logic [CELL_W-1:0] wr_data_q;
  logic              out_all_q, wr_en_q, done_q, ovf_q;
  logic              push, load, last_wr;
  assign in_ready    = state_q == ACTIVE && cnt_q != (PW+1)'(FIFO_DEPTH);
  assign push        = in_valid && in_ready;
  assign load        = (!wr_en_q || mem_ready) && cnt_q != '0;
  // out_all_q marks that the final cell of the frame now sits in the output register
  assign last_wr     = state_q == DRAIN && out_all_q && wr_en_q && mem_ready;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = wr_data_q;
  assign busy        = state_q != IDLE;
  assign frame_done  = done_q;
  assign overflow    = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      in_cnt_q  <= '0;
      col_q     <= '0;
      row_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      out_all_q <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= last_wr;
      cnt_q  <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, load};
      if (push) begin
        fifo_q[wp_q] <= in_data;
        wp_q         <= wp_q + 1'b1;
        in_cnt_q     <= in_cnt_q + 1'b1;
      end
      if (load) begin
        rp_q      <= rp_q + 1'b1;
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_q;
        wr_data_q <= fifo_q[rp_q];
        addr_q    <= addr_q + 1'b1;
        out_all_q <= row_q == YW'(IMG_H - 1) && col_q == XW'(IMG_W - 1);
        col_q     <= col_q == XW'(IMG_W - 1) ? '0 : col_q + 1'b1;
        row_q     <= col_q == XW'(IMG_W - 1) ? row_q + 1'b1 : row_q;
      end else if (mem_ready) begin
        wr_en_q <= 1'b0;
      end
      if (state_q == ACTIVE && in_valid && !in_ready) ovf_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= ACTIVE;
          in_cnt_q  <= '0;
          col_q     <= '0;
          row_q     <= '0;
          out_all_q <= 1'b0;
          ovf_q     <= 1'b0;
          addr_q    <= base_addr;
        end
        ACTIVE: if (push && in_cnt_q == CW'(TOTAL - 1)) state_q <= DRAIN;
        DRAIN: if (last_wr) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cell_frame_writer.sv
// tb_cell_frame_writer: directed frames against a scoreboard of expected {addr, data} writes.
module tb_cell_frame_writer;
  logic       clk = 0, rst = 1, start = 0, in_valid = 0, mem_ready = 1;
  logic [7:0] base_addr = 0, in_data = 0;
  logic       in_ready, mem_wr_en, busy, frame_done, overflow;
  logic [7:0] mem_wr_addr, mem_wr_data;
  logic [15:0] q[$];
  logic [15:0] e;
  logic [7:0] exp_addr = 0, d;
  int n_cmp = 0, n_err = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, exp_done = 0;
  int first_acc = -1, first_wr = -1, last_wr_cyc = 0, w0, k;
  logic acc;

  cell_frame_writer #(.CELL_W(8), .IMG_W(4), .IMG_H(2), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_ready(mem_ready), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [7:0] b, bit accepted);
    base_addr = b;
    start = 1;
    if (accepted) exp_addr = b;
    tick();
    start = 0;
    if (accepted) begin
      chk("start_busy", busy, 1);
      chk("start_ready", in_ready, 1);
    end
  endtask

  task automatic feed(int n, logic [7:0] v);
    int sent = 0;
    int t = 0;
    while (sent < n && t < 200) begin
      in_valid = in_ready;
      in_data = v;
      tick();
      if (in_valid) begin
        sent++;
        v++;
      end
      t++;
    end
    in_valid = 0;
    chk("feed_count", sent, n);
  endtask

  task automatic wait_done(string tag);
    int t = 0;
    exp_done++;
    while (done_cnt < exp_done && t < 60) begin
      tick();
      t++;
    end
    repeat (2) tick();
    chk(tag, done_cnt, exp_done);
    chk({tag, "_queue"}, q.size(), 0);
  endtask

  // monitor: record accepted cells as expected writes, then match each memory write in order
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mem_wr_en && first_wr < 0) first_wr = cyc;
      if (mem_wr_en && mem_ready) begin
        chk("wr_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("wr_addr", mem_wr_addr, e[15:8]);
          chk("wr_data", mem_wr_data, e[7:0]);
        end
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        q.push_back({exp_addr, in_data});
        exp_addr++;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
        chk("done_latency", cyc - last_wr_cyc, 1);
      end
    end
  end

  initial begin
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    rst = 0;
    tick();
    // basic frame, then cells offered during drain
    do_start(8'h10, 1);
    feed(8, 8'h01);
    in_valid = 1;
    in_data = 8'h09;
    for (int i = 0; i < 3; i++) begin
      chk("drain_ready", in_ready, 0);
      tick();
    end
    in_valid = 0;
    wait_done("basic_done");
    chk("basic_latency", first_wr - first_acc, 2);
    chk("basic_ovf", overflow, 0);
    chk("basic_writes", wr_cnt, 8);
    chk("basic_pulse_low", frame_done, 0);
    chk("basic_idle", busy, 0);
    // backpressure without dropping
    do_start(8'h20, 1);
    mem_ready = 0;
    d = 8'h21;
    for (int i = 0; i < 6; i++) begin
      in_valid = in_ready;
      in_data = d;
      tick();
      if (in_valid) d++;
    end
    in_valid = 0;
    chk("bp_full", in_ready, 0);
    chk("bp_accepted", d, 8'h26);
    chk("bp_hold_en", mem_wr_en, 1);
    chk("bp_hold_addr", mem_wr_addr, 8'h20);
    chk("bp_hold_data", mem_wr_data, 8'h21);
    mem_ready = 1;
    feed(3, d);
    wait_done("bp_done");
    chk("bp_ovf", overflow, 0);
    // stall with in_valid held high: drops set overflow
    do_start(8'h30, 1);
    mem_ready = 0;
    d = 8'h31;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_data = d;
      tick();
      d++;
    end
    in_valid = 0;
    chk("ovf_set", overflow, 1);
    mem_ready = 1;
    feed(3, 8'h40);
    wait_done("ovf_done");
    chk("ovf_sticky", overflow, 1);
    // idle input ignored, restart clears overflow, mid-frame start ignored
    in_valid = 1;
    in_data = 8'hEE;
    repeat (3) tick();
    chk("idle_ready", in_ready, 0);
    in_valid = 0;
    do_start(8'h50, 1);
    chk("ovf_cleared", overflow, 0);
    feed(3, 8'h51);
    do_start(8'h99, 0);
    chk("mid_start_busy", busy, 1);
    feed(5, 8'h54);
    wait_done("ign_done");
    chk("ign_ovf", overflow, 0);
    // address wrap
    do_start(8'hFC, 1);
    feed(8, 8'hA0);
    wait_done("wrap_done");
    // reset mid-frame after three writes
    do_start(8'h60, 1);
    w0 = wr_cnt;
    d = 8'hB0;
    k = 0;
    while (wr_cnt < w0 + 3 && k < 50) begin
      in_valid = 1;
      in_data = d;
      acc = in_ready;
      tick();
      if (acc) d++;
      k++;
    end
    chk("mid_writes", wr_cnt, w0 + 3);
    rst = 1;
    in_valid = 0;
    mem_ready = 0;
    tick();
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_wr_en", mem_wr_en, 0);
    chk("mrst_wr_addr", mem_wr_addr, 0);
    chk("mrst_wr_data", mem_wr_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", frame_done, 0);
    chk("mrst_ovf", overflow, 0);
    rst = 0;
    q.delete();
    mem_ready = 1;
    repeat (4) tick();
    chk("mrst_no_writes", wr_cnt, w0 + 3);
    do_start(8'h40, 1);
    feed(8, 8'hC0);
    wait_done("after_rst_done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
